// File: rtl/rv32ic_ins_aligner_pkg.sv
// Shared RISC-V defines for the fetch/align path: halfword width, parcel
// length encoding and aligner FIFO sizing.
package rv32ic_ins_aligner_pkg;

  localparam int unsigned HW_W       = 16;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 3;

  // Low two bits of a parcel equal to this mark a 32-bit instruction.
  localparam logic [1:0] RV_LEN32_PAT = 2'b11;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic is_compressed(input logic [HW_W-1:0] parcel);
    return parcel[1:0] != RV_LEN32_PAT;
  endfunction

endpackage

// File: rtl/rv32ic_ins_aligner.sv
// Repacks word-aligned fetch data into whole 16/32-bit instructions using a
// 4-entry halfword FIFO; each instruction carries its PC and fetch error.
module rv32ic_ins_aligner
  import rv32ic_ins_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  input  logic        fetch_err_i,
  output logic        ins_valid_o,
  input  logic        ins_ready_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_pc_o,
  output logic        ins_err_o
);

  logic [FIFO_DEPTH-1:0][HW_W-1:0] data_q, data_d, data_shift_c;
  logic [FIFO_DEPTH-1:0]           err_q, err_d, err_shift_c;
  logic [CNT_W-1:0]                count_q, count_d, count_pop_c;
  logic [XLEN-1:0]                 pc_q, pc_d;
  logic                            drop_lo_q, drop_lo_d;

  logic            valid_c, push_c;
  logic [1:0]      pop_n_c, pop_amt_c, push_n_c;
  logic [HW_W-1:0] push_lo_c;

  // Head decode: valid / length / payload from registered FIFO state only.
  always_comb begin
    valid_c   = 1'b0;
    pop_n_c   = 2'd0;
    ins_o     = '0;
    ins_err_o = 1'b0;
    if (count_q != '0) begin
      if (is_compressed(data_q[0])) begin
        valid_c   = 1'b1;
        pop_n_c   = 2'd1;
        ins_o     = {{HW_W{1'b0}}, data_q[0]};
        ins_err_o = err_q[0];
      end else if (count_q >= CNT_W'(2)) begin
        valid_c   = 1'b1;
        pop_n_c   = 2'd2;
        ins_o     = {data_q[1], data_q[0]};
        ins_err_o = err_q[0] | err_q[1];
      end else if (err_q[0]) begin
        // Faulting lower half is reported alone; the upper half never arrives.
        valid_c   = 1'b1;
        pop_n_c   = 2'd1;
        ins_o     = {data_q[1], data_q[0]};
        ins_err_o = 1'b1;
      end
    end
  end

  assign ins_valid_o   = valid_c;
  assign ins_pc_o      = pc_q;
  assign fetch_ready_o = (count_q <= CNT_W'(2));
  assign push_c        = fetch_valid_i & fetch_ready_o;

  // Next state: shift out popped entries, append pushed halves behind them.
  always_comb begin
    pop_amt_c    = (valid_c && ins_ready_i) ? pop_n_c : 2'd0;
    data_shift_c = data_q >> (HW_W * pop_amt_c);
    err_shift_c  = err_q >> pop_amt_c;
    count_pop_c  = count_q - CNT_W'(pop_amt_c);
    push_lo_c    = drop_lo_q ? fetch_data_i[31:16] : fetch_data_i[15:0];
    push_n_c     = drop_lo_q ? 2'd1 : 2'd2;

    data_d    = data_shift_c;
    err_d     = err_shift_c;
    count_d   = count_pop_c;
    pc_d      = pc_q + (XLEN'(pop_amt_c) << 1);
    drop_lo_d = drop_lo_q;

    if (push_c) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (CNT_W'(i) == count_pop_c) begin
          data_d[i] = push_lo_c;
          err_d[i]  = fetch_err_i;
        end
        if (!drop_lo_q && (CNT_W'(i) == count_pop_c + CNT_W'(1))) begin
          data_d[i] = fetch_data_i[31:16];
          err_d[i]  = fetch_err_i;
        end
      end
      count_d   = count_pop_c + CNT_W'(push_n_c);
      drop_lo_d = 1'b0;
    end

    if (flush_i) begin
      data_d    = data_q;
      err_d     = err_q;
      count_d   = '0;
      pc_d      = {flush_pc_i[31:1], 1'b0};
      drop_lo_d = flush_pc_i[1];
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      data_q    <= '0;
      err_q     <= '0;
      count_q   <= '0;
      pc_q      <= {RESET_PC[31:1], 1'b0};
      drop_lo_q <= RESET_PC[1];
    end else begin
      data_q    <= data_d;
      err_q     <= err_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      drop_lo_q <= drop_lo_d;
    end
  end

endmodule

// File: doc/rv32ic_ins_aligner.md
# rv32ic_ins_aligner

Instruction-parcel aligner between the fetch bus and the RVC expander. It accepts word-aligned 32-bit fetch data and repacks it into a stream of whole instructions. The stream is either a 16-bit compressed parcel or a 32-bit instruction that may straddle two fetch words. Each instruction carries its own PC and fetch-error flag. Its output feeds the compressed-instruction expander and the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 ignored, bit 1 honoured.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- resetb_i  in  1  reset, asynchronous assert, active-low.
- flush_i  in  1  redirect; discards all buffered parcels.
- flush_pc_i  in  32  redirect target; bit 0 ignored.
- fetch_valid_i  in  1  fetch word valid.
- fetch_ready_o  out  1  aligner can accept a fetch word.
- fetch_data_i  in  32  word-aligned fetch data, little-endian halfwords.
- fetch_err_i  in  1  bus error for this fetch word.
- ins_valid_o  out  1  complete instruction available.
- ins_ready_i  in  1  consumer takes the instruction.
- ins_o  out  32  instruction; for a compressed instruction, [15:0] is the parcel and [31:16] is zero.
- ins_pc_o  out  32  PC of ins_o; bit 0 always 0.
- ins_err_o  out  1  fetch error in any halfword of this instruction.

## Operation
- Storage is a 4-entry halfword FIFO: data[16], err[1] per entry, plus count[2:0] (0..4), head PC, and a drop_lo flag.
- Length detection: the head halfword is compressed when bits[1:0] != 2'b11. It needs 1 entry if compressed, otherwise 2.
- ins_valid_o is asserted when any of the following holds:
  - count >= 1 and the head is compressed;
  - count >= 2;
  - count >= 1 and the head err = 1. The error is reported without waiting for the upper half; ins_o is then don't-care.
- Pop occurs when ins_valid_o && ins_ready_i. It removes 1 or 2 entries; on an error-only pop of an uncompressed head it removes 1 entry.
  - On pop, head PC advances by 2 for a 1-entry pop or by 4 for a 2-entry pop, modulo 2^32.
- ins_err_o is the OR of err over the consumed entries.
- fetch_ready_o = (count <= 2), taken from registered count only. There is no combinational path from ins_ready_i.
- Push occurs when fetch_valid_i && fetch_ready_o. Both halves are appended, low half first, each tagged with fetch_err_i.
  - If drop_lo = 1, only the high half is appended and drop_lo clears.
- Push and pop in the same cycle are allowed. Next count = count − popped + pushed, and never exceeds 4.
- Flush has the highest priority. On flush:
  - count ← 0, head PC ← {flush_pc_i[31:1],1'b0}, drop_lo ← flush_pc_i[1];
  - any push or pop in that cycle is discarded;
  - outputs are still driven combinationally from the pre-flush state, and the consumer must ignore them;
  - fetch_ready_o is not gated by flush.
- No halfword is ever duplicated or lost except on flush.

## Timing
- Reset values: count = 0, ins_valid_o = 0, fetch_ready_o = 1, ins_pc_o = {RESET_PC[31:1],0}, drop_lo = RESET_PC[1], ins_o = 0, ins_err_o = 0.
- Latency: a word accepted in cycle N gives ins_valid_o in cycle N+1 at the earliest.
- A 32-bit instruction straddling two words becomes valid one cycle after the second word is accepted.
- Throughput:
  - one instruction per cycle while data is sustained;
  - with all-compressed code, one fetch word per two cycles;
  - stalls never drop data, and ins_o, ins_pc_o, ins_err_o hold stable while ins_valid_o && !ins_ready_i.
- Boundaries:
  - count = 3 → fetch_ready_o = 0, even if a pop happens that cycle;
  - count = 1 holding an uncompressed head without error → ins_valid_o = 0;
  - PC wraps 32'hFFFF_FFFE → 32'h0000_0000.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first post-reset edge then behaves as the reset state.

## Structure
- Length-detect constant (2'b11 low-bit pattern) and the halfword width belong in the shared riscv_defs header, alongside the opcode definitions.
- Single module, no sub-module. The FIFO is small enough to be inline registers with explicit shift-on-pop muxing.
- The parent instantiates this block and connects ins_o[15:0] to the expander. The parent selects expander output vs. ins_o using the compressed flag.

## Test plan
- Reset with RESET_PC = 0, then push words 32'h0001_4501 and 32'h0002_8082 → four compressed instructions at PC 0, 2, 4, 6 with ins_o[31:16] = 0, err = 0.
- Flush to 32'h102, then push word 32'h0041_0113 → the first output is the 16'h0041 parcel at PC 0x102; the low half is dropped; the next PC is 0x104.
- Straddle: PC 0, words 32'h0513_0001 then 32'hxxxx_0000 → c.nop at PC 0, then 32'h0000_0513 at PC 2, valid one cycle after the second word.
- Hold ins_ready_i = 0 with words streaming → fetch_ready_o deasserts at count = 3, no data lost, outputs stable; release → in-order drain.
- Fetch error on a word whose high half starts a 32-bit instruction → that instruction is reported with ins_err_o = 1 before the next word arrives.
- Flush and push in the same cycle, and reset asserted mid-stream → the pushed word is discarded; reset gives count = 0 and ins_valid_o = 0 immediately.
